// File: rtl/bit_stream_gen_if.sv
// Handshake and serial-output bundle of the parallel-to-serial pattern generator.
// The repeat request is carried as repeat_en because "repeat" is a SystemVerilog keyword.
interface bit_stream_gen_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             repeat_en;
  logic             abort;
  logic [WIDTH-1:0] data;
  logic             x;
  logic             x_stb;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_en, abort, data,
    input  x, x_stb, busy, done
  );

  modport slave (
    input  start, repeat_en, abort, data,
    output x, x_stb, busy, done
  );
endinterface

// File: rtl/bit_stream_gen.sv
// Parallel-to-serial pattern generator: one bit every TICK_DIV clocks, with a strobe per bit.
// Optional macro BITGEN_LSB_FIRST_EN emits data[0] first instead of data[WIDTH-1].
module bit_stream_gen #(
  parameter int WIDTH    = 6,
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input logic            clk,
  input logic            rst_n,
  bit_stream_gen_if.slave bus
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] pat_r;
  logic [IDX_W-1:0] idx_r;
  logic [DIV_W-1:0] div_r;
  logic             first_r;
  logic             x_r;
  logic             x_stb_r;
  logic             busy_r;
  logic             done_r;

  logic             tick_s;
  logic             pass_end_s;
  logic             head_s;
  logic [WIDTH-1:0] rot_s;

  // The pattern register rotates, so after a full pass it is back to the captured value
  // and a repeat pass can start from it without re-sampling data.
`ifdef BITGEN_LSB_FIRST_EN
  assign head_s = pat_r[0];
  assign rot_s  = {pat_r[0], pat_r[WIDTH-1:1]};
`else
  assign head_s = pat_r[WIDTH-1];
  assign rot_s  = {pat_r[WIDTH-2:0], pat_r[WIDTH-1]};
`endif

  // first_r forces the strobe on the edge right after acceptance; later strobes come from the divider
  assign tick_s     = first_r | (div_r == DIV_LAST);
  assign pass_end_s = (idx_r == IDX_ZERO) & ~first_r;

  // Streaming state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pat_r   <= {WIDTH{1'b0}};
      idx_r   <= IDX_ZERO;
      div_r   <= DIV_ZERO;
      first_r <= 1'b0;
      x_r     <= 1'b0;
      x_stb_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          x_r     <= 1'b0;
          x_stb_r <= 1'b0;
          done_r  <= 1'b0;
          if (bus.start && !bus.abort) begin
            pat_r   <= bus.data;
            idx_r   <= IDX_ZERO;
            div_r   <= DIV_ZERO;
            first_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            idx_r   <= IDX_ZERO;
            div_r   <= DIV_ZERO;
            first_r <= 1'b0;
            x_r     <= 1'b0;
            x_stb_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            state_r <= IDLE;
          end else if (!tick_s) begin
            div_r   <= div_r + DIV_ONE;
            x_stb_r <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            div_r   <= DIV_ZERO;
            first_r <= 1'b0;
            done_r  <= pass_end_s;
            if (pass_end_s && !bus.repeat_en) begin
              x_r     <= 1'b0;
              x_stb_r <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              x_r     <= head_s;
              x_stb_r <= 1'b1;
              pat_r   <= rot_s;
              idx_r   <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
            end
          end
        end
        default: begin
          idx_r   <= IDX_ZERO;
          div_r   <= DIV_ZERO;
          first_r <= 1'b0;
          x_r     <= 1'b0;
          x_stb_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.x     = x_r;
  assign bus.x_stb = x_stb_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_bit_stream_gen.sv
// Scoreboard bench for bit_stream_gen: expected per-cycle outputs are queued from the
// stimulus and compared each cycle, one task per scenario.
module tb_bit_stream_gen;

  localparam int W = 6;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bit_stream_gen_if #(.WIDTH(W)) bus4 ();
  bit_stream_gen_if #(.WIDTH(W)) bus1 ();

  bit_stream_gen #(.WIDTH(W), .TICK_DIV(T), .DIV_W(26)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  bit_stream_gen #(.WIDTH(W), .TICK_DIV(1), .DIV_W(26)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct packed {
    logic x;
    logic stb;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];

  function automatic logic model_bit(input logic [W-1:0] d, input int k);
`ifdef BITGEN_LSB_FIRST_EN
    return d[k];
`else
    return d[W-1-k];
`endif
  endfunction

  // Expected outputs for edges 1.. after an accepted start (edge 0)
  function automatic void push_stream(input logic [W-1:0] d, input int tdiv,
                                      input int passes, input int idle);
    exp_t e;
    for (int p = 0; p < passes; p++) begin
      for (int c = 1; c <= W * tdiv; c++) begin
        e.x    = model_bit(d, (c - 1) / tdiv);
        e.stb  = ((c - 1) % tdiv) == 0;
        e.busy = 1'b1;
        e.done = (p > 0) && (c == 1);
        sb.push_back(e);
      end
    end
    e = '{x: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b1};
    sb.push_back(e);
    for (int i = 0; i < idle; i++) begin
      e = '{x: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b0};
      sb.push_back(e);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass4(input logic [W-1:0] d);
    bus4.data  = d;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t obs;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.repeat_en = 1'b0; bus4.abort = 1'b0; bus4.data = '0;
    bus1.start = 1'b0; bus1.repeat_en = 1'b0; bus1.abort = 1'b0; bus1.data = '0;
    step();
    step();
    obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut4: got %b want 0000", obs);
    end
    obs = {bus1.x, bus1.x_stb, bus1.busy, bus1.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b want 0000", obs);
    end
    rst_n = 1'b1;
    step();
    obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000", obs);
    end
  endtask

  task automatic test_one_shot();
    exp_t obs, e;
    start_pass4(6'b110010);
    n_checks++;
    if ({bus4.busy, bus4.x_stb} !== 2'b10) begin
      n_fail++;
      $display("FAIL accept_edge: got busy/stb %b want 10", {bus4.busy, bus4.x_stb});
    end
    push_stream(6'b110010, T, 1, 3);
    for (int c = 1; sb.size() > 0; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL one_shot edge %0d: got x/stb/busy/done %b want %b", c, obs, e);
      end
    end
  endtask

  task automatic test_repeat();
    exp_t obs, e;
    bus4.repeat_en = 1'b1;
    start_pass4(6'b110010);
    push_stream(6'b110010, T, 3, 3);
    for (int c = 1; sb.size() > 0; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL repeat edge %0d: got x/stb/busy/done %b want %b", c, obs, e);
      end
      if (c == 50) bus4.repeat_en = 1'b0;
    end
  endtask

  task automatic test_abort();
    exp_t obs, e;
    start_pass4(6'b110010);
    push_stream(6'b110010, T, 1, 0);
    for (int c = 1; c <= 9; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_pre edge %0d: got %b want %b", c, obs, e);
      end
    end
    sb.delete();
    bus4.abort = 1'b1;
    step();
    bus4.abort = 1'b0;
    obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_edge10: got %b want 0000", obs);
    end
    step();
    obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_edge11: got %b want 0000", obs);
    end
    start_pass4(6'b101101);
    push_stream(6'b101101, T, 1, 1);
    for (int c = 1; sb.size() > 0; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_restart edge %0d: got %b want %b", c, obs, e);
      end
    end
    bus4.abort = 1'b1;
    bus4.start = 1'b1;
    step();
    bus4.abort = 1'b0;
    bus4.start = 1'b0;
    n_checks++;
    if (bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_blocks_start: got busy %b want 0", bus4.busy);
    end
  endtask

  task automatic test_busy_inputs();
    exp_t obs, e;
    start_pass4(6'b110010);
    push_stream(6'b110010, T, 1, 2);
    for (int c = 1; sb.size() > 0; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL busy_inputs edge %0d: got %b want %b", c, obs, e);
      end
      if (c == 6) begin
        bus4.start = 1'b1;
        bus4.data  = 6'b000000;
      end
      if (c == 7) bus4.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs, e;
    start_pass4(6'b110010);
    push_stream(6'b110010, T, 1, 0);
    for (int c = 1; c <= 14; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre edge %0d: got %b want %b", c, obs, e);
      end
    end
    sb.delete();
    #1 rst_n = 1'b0;
    #1;
    obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b want 0000", obs);
    end
    step();
    rst_n = 1'b1;
    step();
    obs = {bus4.x, bus4.x_stb, bus4.busy, bus4.done};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %b want 0000", obs);
    end
  endtask

  task automatic test_tick1();
    exp_t obs, e;
    bus1.data  = 6'b110110;
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    push_stream(6'b110110, 1, 1, 2);
    for (int c = 1; sb.size() > 0; c++) begin
      step();
      e = sb.pop_front();
      obs = {bus1.x, bus1.x_stb, bus1.busy, bus1.done};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL tick1 edge %0d: got %b want %b", c, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_repeat();
    test_abort();
    test_busy_inputs();
    test_reset_mid();
    test_tick1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_stream_gen.md
Name: bit_stream_gen

Overview:
- Parallel-to-serial pattern generator feeding the serial input of the sequence detector.
- Captures a WIDTH-bit pattern, usually from board switches, on a start request.
- Presents the pattern one bit at a time on x, one bit every TICK_DIV clocks, with a one-cycle x_stb pulse marking each new bit; the detector is clock-enabled by x_stb.
- Supports one-shot and continuous-repeat modes, plus abort.

Parameters:
WIDTH, 6, pattern length in bits (>=2)
TICK_DIV, 50000000, clk cycles per serial bit (>=1)
DIV_W, 26, divider counter width; must hold TICK_DIV-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level, sampled each edge; starts a pass when idle
repeat  input  1  1 = restart pattern seamlessly at end of pass
abort  input  1  1 = terminate stream immediately
data  input  WIDTH  pattern to serialise, captured on accepted start
x  output  1  current serial bit
x_stb  output  1  one-cycle pulse when x takes a new bit
busy  output  1  high while streaming
done  output  1  one-cycle pulse at end of a pass

Behaviour:
- Reset (async, rst_n=0): x=0, x_stb=0, busy=0, done=0, divider=0, bit index=0, shift register=0, state=IDLE. Release is synchronous to the next edge; no output glitches on release.
- States: IDLE, SHIFT.
- IDLE:
  - Outputs: busy=0, x=0, x_stb=0, done=0.
  - On an edge with start=1 and abort=0: capture data into the shift register, index=0, divider=0, busy<=1, go to SHIFT.
- SHIFT timing: with the accepting edge as cycle 0, bit k is driven on x with x_stb=1 at edge 1+k*TICK_DIV.
  - x holds that value until the next bit edge.
  - x_stb is high for exactly one cycle per bit.
  - Divider counts 0..TICK_DIV-1 between strobes and wraps to 0 at each strobe.
- Bit order: MSB first (data[WIDTH-1] first), unless the optional feature is enabled.
- End of pass: at edge 1+WIDTH*TICK_DIV, done=1 for one cycle. repeat is sampled at this edge.
  - repeat=0: busy<=0, x<=0, x_stb=0, return to IDLE. start high on that same edge is not accepted; it is accepted from the following edge.
  - repeat=1: same edge also drives bit 0 of the captured pattern with x_stb=1. Strobe spacing stays exactly TICK_DIV with no gap, and busy stays 1. The captured pattern is reused; data is not re-sampled.
- abort=1 in SHIFT: at that edge go to IDLE, busy<=0, x<=0; no x_stb and no done that cycle. abort has priority over strobe, done and start. abort in IDLE has no effect, and blocks start on the same edge.
- start while busy: ignored.
- data changes while busy: no effect.
- TICK_DIV=1: x_stb is continuously high while streaming, with a new bit every cycle.
- Divider and index never exceed TICK_DIV-1 and WIDTH-1.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BITGEN_LSB_FIRST_EN.
- Defined: bits are emitted LSB first (data[0] first); all timing is unchanged.
- Undefined: MSB first.

Test Plan:
- One-shot (WIDTH=6, TICK_DIV=4, data=6'b110010, start pulse accepted at edge 0, repeat=0):
  - x_stb at edges 1,5,9,13,17,21 with x=1,1,0,0,1,0.
  - done pulse at edge 25, where busy falls and x=0.
- Repeat: same setup with repeat=1.
  - done at 25 coincides with x_stb and x=1 (bit 0 again).
  - Strobes continue every 4 cycles with period-24 pattern repetition; done at 49 and 73.
  - Deassert repeat before edge 49: stream stops at 49.
- Abort: abort=1 at edge 10 during the one-shot pass.
  - busy=0 and x=0 after edge 10.
  - No further x_stb and no done.
  - A new start at edge 12 restarts cleanly at bit 0.
- Start/data while busy: pulse start and change data to 6'b000000 at edge 7.
  - Output sequence is unchanged (110010) and done still occurs at edge 25.
- Reset mid-stream and TICK_DIV=1:
  - rst_n=0 at edge 14: all outputs 0 immediately (asynchronously).
  - With TICK_DIV=1 and data=6'b110110, x_stb is high for edges 1-6 with x=1,1,0,1,1,0, then done at edge 7.
- With BITGEN_LSB_FIRST_EN defined and data=6'b110010: x sequence is 0,1,0,0,1,1 at the same edges.
